// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS-subset datapath: opcodes,
// funct codes, ALU control and FSM state encoding.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    function automatic logic [2:0] funct_ctl(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op,
                                      input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) ||
                             (fn == FN_AND) || (fn == FN_OR) ||
                             (fn == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Unified memory port: one request/ready handshake shared by
// instruction fetch and data load/store.
interface mc_datapath_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_regfile.sv
// Register file: two asynchronous reads, one synchronous write,
// asynchronous active-low clear; R0 is hardwired to zero.
module mc_regfile #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [31:0]           rd1,
    output logic [31:0]           rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [31:0]           wd
);
    localparam int NREG = 2 ** REG_ADDR_W;

    logic [31:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath with control FSM and unified memory port.
// Define MCDP_ILLEGAL_TRAP_EN to halt on illegal instructions instead of NOP.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 32,
    parameter int          REG_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_datapath_if.master        mem,
    output logic [31:0]          pc,
    output logic                 halted,
    output logic [2:0]           state
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d;

    logic [5:0]            op, fn;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [31:0]           imm, rd1, rd2;
    logic [31:0]           alu_b, alu_y, addr_full;
    logic [2:0]            alu_ctl;
    logic                  accept, rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic [31:0]           rf_wd;

    assign op  = ir_q[31:26];
    assign fn  = ir_q[5:0];
    assign rs  = ir_q[21 +: REG_ADDR_W];
    assign rt  = ir_q[16 +: REG_ADDR_W];
    assign rd  = ir_q[11 +: REG_ADDR_W];
    assign imm = {{16{ir_q[15]}}, ir_q[15:0]};

    mc_regfile #(.REG_ADDR_W(REG_ADDR_W)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    assign alu_ctl = (op == OP_RTYPE) ? funct_ctl(fn) : ALU_ADD;
    assign alu_b   = (op == OP_RTYPE) ? b_q : imm;

    always_comb begin
        case (alu_ctl)
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(a_q) < $signed(alu_b)};
            default: alu_y = a_q + alu_b;
        endcase
    end

    // Request lines decode from registered state only; reset gates them
    // so an in-flight access is dropped the moment rst falls.
    assign addr_full     = (state_q == S_MEM) ? aluout_q : pc_q;
    assign mem.mem_req   = rst & ((state_q == S_FETCH) | (state_q == S_MEM));
    assign mem.mem_we    = rst & (state_q == S_MEM) & (op == OP_SW);
    assign mem.mem_addr  = rst ? addr_full[ADDR_W-1:0] : '0;
    assign mem.mem_wdata = b_q;
    assign accept        = mem.mem_req & mem.mem_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_wa    = rt;
        rf_wd    = aluout_q;
        case (state_q)
            S_FETCH: if (accept) begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (1'b1)
                    !is_legal(op, fn): begin
`ifdef MCDP_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end
                    (op == OP_RTYPE), (op == OP_ADDI): begin
                        aluout_d = alu_y;
                        state_d  = S_WB;
                    end
                    (op == OP_LW), (op == OP_SW): begin
                        aluout_d = a_q + imm;
                        state_d  = S_MEM;
                    end
                    (op == OP_BEQ): begin
                        if (a_q == b_q) pc_d = pc_q + {imm[29:0], 2'b00};
                    end
                    (op == OP_J): begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    end
                    default: ;
                endcase
            end
            S_MEM: if (accept) begin
                if (op == OP_SW) begin
                    state_d = S_FETCH;
                end else begin
                    mdr_d   = mem.mem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_RTYPE) ? rd : rt;
                rf_wd   = (op == OP_LW) ? mdr_q : aluout_q;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    assign pc    = pc_q;
    assign state = state_q;
`ifdef MCDP_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: fetch, wait states, load/store,
// ALU ops, branch/jump, illegal opcode and mid-access reset.
module tb_mc_datapath;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic [2:0]  state;

    logic [31:0] imem [0:255];
    logic [31:0] dword = 32'h0;
    int          st_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    mc_datapath_if #(.ADDR_W(32)) ifc ();

    mc_datapath #(
        .RESET_PC   (32'h0),
        .ADDR_W     (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem    (ifc.master),
        .pc     (pc),
        .halted (halted),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Instruction memory everywhere except one data word at 0x80.
    assign ifc.mem_rdata = (ifc.mem_addr == 32'h80) ? dword
                                                    : imem[ifc.mem_addr[9:2]];

    always @(posedge clk) begin
        if (ifc.mem_req && ifc.mem_ready && ifc.mem_we &&
            ifc.mem_addr == 32'h80) begin
            dword  <= ifc.mem_wdata;
            st_cnt <= st_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (ifc.mem_req !== 1'b0) begin errors++;
            $display("FAIL rst_req got %b exp 0", ifc.mem_req); end
        checks++;
        if (pc !== 32'h0 || state !== 3'd0 || halted !== 1'b0) begin errors++;
            $display("FAIL rst_state got pc=%h st=%0d h=%b exp 0/0/0", pc, state, halted); end
        checks++;
        if (ifc.mem_addr !== 32'h0 || ifc.mem_wdata !== 32'h0) begin errors++;
            $display("FAIL rst_bus got a=%h d=%h exp 0/0", ifc.mem_addr, ifc.mem_wdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 32'h0 || ifc.mem_we !== 1'b0) begin errors++;
            $display("FAIL first_req got r=%b a=%h w=%b exp 1/0/0", ifc.mem_req, ifc.mem_addr, ifc.mem_we); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi;
        tick(2);
        checks++;
        if (state !== 3'd4 || dut.u_rf.regs_q[1] !== 32'h0) begin errors++;
            $display("FAIL addi_wb got st=%0d r1=%h exp 4/0", state, dut.u_rf.regs_q[1]); end
        tick(1);
        checks++;
        if (dut.u_rf.regs_q[1] !== 32'd5 || pc !== 32'h4 || state !== 3'd0) begin errors++;
            $display("FAIL addi got r1=%h pc=%h st=%0d exp 5/4/0", dut.u_rf.regs_q[1], pc, state); end
    endtask

    task automatic test_wait_states;
        ifc.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 32'h4 || state !== 3'd0) begin errors++;
                $display("FAIL wait_%0d got r=%b a=%h st=%0d exp 1/4/0", i, ifc.mem_req, ifc.mem_addr, state); end
            tick(1);
        end
        ifc.mem_ready = 1'b1;
        checks++;
        if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 32'h4 || pc !== 32'h4) begin errors++;
            $display("FAIL wait_acc got r=%b a=%h pc=%h exp 1/4/4", ifc.mem_req, ifc.mem_addr, pc); end
        tick(3);
        checks++;
        if (dut.u_rf.regs_q[4] !== 32'h0) begin errors++;
            $display("FAIL wait_early got r4=%h exp 0", dut.u_rf.regs_q[4]); end
        tick(1);
        checks++;
        if (dut.u_rf.regs_q[4] !== 32'hFFFF_FFFF || pc !== 32'h8) begin errors++;
            $display("FAIL wait_done got r4=%h pc=%h exp ffffffff/8", dut.u_rf.regs_q[4], pc); end
    endtask

    task automatic test_load_store;
        tick(3);
        checks++;
        if (state !== 3'd3 || ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b1 ||
            ifc.mem_addr !== 32'h80 || ifc.mem_wdata !== 32'd5) begin errors++;
            $display("FAIL sw_req got st=%0d r=%b w=%b a=%h d=%h exp 3/1/1/80/5",
                     state, ifc.mem_req, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata); end
        tick(1);
        checks++;
        if (state !== 3'd0 || pc !== 32'hC || st_cnt !== 1 || dword !== 32'd5) begin errors++;
            $display("FAIL sw_done got st=%0d pc=%h n=%0d m=%h exp 0/c/1/5", state, pc, st_cnt, dword); end
        tick(3);
        checks++;
        if (state !== 3'd3 || ifc.mem_we !== 1'b0 || ifc.mem_addr !== 32'h80) begin errors++;
            $display("FAIL lw_req got st=%0d w=%b a=%h exp 3/0/80", state, ifc.mem_we, ifc.mem_addr); end
        tick(1);
        checks++;
        if (state !== 3'd4 || dut.u_rf.regs_q[2] !== 32'h0) begin errors++;
            $display("FAIL lw_wb got st=%0d r2=%h exp 4/0", state, dut.u_rf.regs_q[2]); end
        tick(1);
        checks++;
        if (dut.u_rf.regs_q[2] !== 32'd5 || pc !== 32'h10 || state !== 3'd0) begin errors++;
            $display("FAIL lw_done got r2=%h pc=%h st=%0d exp 5/10/0", dut.u_rf.regs_q[2], pc, state); end
    endtask

    task automatic test_alu;
        tick(4);
        checks++;
        if (dut.u_rf.regs_q[3] !== 32'd1) begin errors++;
            $display("FAIL slt got r3=%h exp 1", dut.u_rf.regs_q[3]); end
        tick(4);
        checks++;
        if (dut.u_rf.regs_q[0] !== 32'h0 || dut.u_rf.rd1 === 32'hA) begin errors++;
            $display("FAIL r0 got r0=%h exp 0", dut.u_rf.regs_q[0]); end
        tick(4);
        checks++;
        if (dut.u_rf.regs_q[5] !== 32'd6 || pc !== 32'h1C) begin errors++;
            $display("FAIL sub got r5=%h pc=%h exp 6/1c", dut.u_rf.regs_q[5], pc); end
    endtask

    task automatic test_branch_jump;
        tick(3);
        checks++;
        if (pc !== 32'h1C || state !== 3'd0) begin errors++;
            $display("FAIL beq got pc=%h st=%0d exp 1c/0", pc, state); end
        imem[7] = 32'h0800_0040;
        tick(3);
        checks++;
        if (pc !== 32'h100 || ifc.mem_addr !== 32'h100 || ifc.mem_req !== 1'b1) begin errors++;
            $display("FAIL jump got pc=%h a=%h r=%b exp 100/100/1", pc, ifc.mem_addr, ifc.mem_req); end
    endtask

    task automatic test_illegal;
        tick(3);
`ifdef MCDP_ILLEGAL_TRAP_EN
        checks++;
        if (state !== 3'd5 || halted !== 1'b1 || ifc.mem_req !== 1'b0 || pc !== 32'h104) begin errors++;
            $display("FAIL trap got st=%0d h=%b r=%b pc=%h exp 5/1/0/104", state, halted, ifc.mem_req, pc); end
        tick(4);
        checks++;
        if (state !== 3'd5 || ifc.mem_req !== 1'b0 || pc !== 32'h104) begin errors++;
            $display("FAIL trap_hold got st=%0d r=%b pc=%h exp 5/0/104", state, ifc.mem_req, pc); end
`else
        checks++;
        if (state !== 3'd0 || halted !== 1'b0 || ifc.mem_req !== 1'b1 ||
            pc !== 32'h104 || ifc.mem_addr !== 32'h104) begin errors++;
            $display("FAIL nop got st=%0d h=%b r=%b pc=%h a=%h exp 0/0/1/104/104",
                     state, halted, ifc.mem_req, pc, ifc.mem_addr); end
`endif
    endtask

    task automatic test_mid_reset;
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        rst = 1'b1;
        tick(11);
        ifc.mem_ready = 1'b0;
        tick(1);
        checks++;
        if (state !== 3'd3 || ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b1) begin errors++;
            $display("FAIL mr_mem got st=%0d r=%b w=%b exp 3/1/1", state, ifc.mem_req, ifc.mem_we); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.mem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0 ||
            dut.u_rf.regs_q[1] !== 32'h0) begin errors++;
            $display("FAIL mr_async got r=%b st=%0d pc=%h r1=%h exp 0/0/0/0",
                     ifc.mem_req, state, pc, dut.u_rf.regs_q[1]); end
        @(negedge clk);
        ifc.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h0 || ifc.mem_req !== 1'b1 || ifc.mem_addr !== 32'h0 ||
            st_cnt !== 1 || halted !== 1'b0) begin errors++;
            $display("FAIL mr_release got pc=%h r=%b a=%h n=%0d h=%b exp 0/1/0/1/0",
                     pc, ifc.mem_req, ifc.mem_addr, st_cnt, halted); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0]  = 32'h2001_0005;
        imem[1]  = 32'h2004_FFFF;
        imem[2]  = 32'hAC01_0080;
        imem[3]  = 32'h8C02_0080;
        imem[4]  = 32'h0081_182A;
        imem[5]  = 32'h0021_0020;
        imem[6]  = 32'h0024_2822;
        imem[7]  = 32'h1021_FFFF;
        imem[64] = 32'hFC00_0000;
        ifc.mem_ready = 1'b1;
        test_reset();
        test_addi();
        test_wait_states();
        test_load_store();
        test_alu();
        test_branch_jump();
        test_illegal();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
